// File: rtl/overlay_pkg.sv
// Shared types and default frame constants for the overlay sequencer.
//   game_state_e : encoding of the gameState input from the game FSM
//   seq_state_e  : internal sequencer states
//   max_u        : helper used to size the shared frame counter
package overlay_pkg;

    localparam int unsigned DEF_BLINK_FRAMES    = 30;
    localparam int unsigned DEF_BANNER_FRAMES   = 120;
    localparam int unsigned DEF_GAMEOVER_FRAMES = 180;

    typedef enum logic [1:0] {
        GS_TITLE    = 2'd0,
        GS_PLAY     = 2'd1,
        GS_GAMEOVER = 2'd2,
        GS_PAUSE    = 2'd3
    } game_state_e;

    typedef enum logic [2:0] {
        S_TITLE     = 3'd0,
        S_BANNER    = 3'd1,
        S_PLAY      = 3'd2,
        S_PAUSE     = 3'd3,
        S_OVER      = 3'd4,
        S_OVER_DONE = 3'd5
    } seq_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/overlay_blink_gen.sv
// Frame-based blink phase generator, shared by all blinking overlays.
//   clk, reset     : clock, synchronous active-high reset (phase -> 1)
//   restart        : re-arm the phase to visible and clear the frame count
//   startOfFrame   : one pulse per video frame
//   phase          : registered blink phase (1 = visible)
//   phase_next_c   : value phase takes at the next edge, so the sequencer
//                    can register its outputs without an extra cycle of lag
module overlay_blink_gen
    import overlay_pkg::*;
#(
    parameter int unsigned BLINK_FRAMES = DEF_BLINK_FRAMES
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic startOfFrame,
    output logic phase,
    output logic phase_next_c
);

    localparam int unsigned CNT_W = $clog2(BLINK_FRAMES) + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    // Restart wins over a coincident frame pulse; toggle every BLINK_FRAMES frames.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (restart) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (startOfFrame) begin
            if (cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase        = phase_q;
    assign phase_next_c = phase_d;

endmodule

// File: rtl/overlay_sequencer.sv
// Frame-timed sequencer producing overlay visibility enables from the
// game-state FSM: blinking prompts, timed level banner, pause, game-over hold.
//   clk, reset         : clock, synchronous active-high reset
//   startOfFrame       : one pulse per video frame
//   gameState[1:0]     : 0=TITLE 1=PLAY 2=GAMEOVER 3=PAUSE
//   levelUp            : one pulse on level advance
//   *Visible           : registered overlay enables
//   gameOverDone       : one-cycle pulse when the game-over hold expires
module overlay_sequencer
    import overlay_pkg::*;
#(
    parameter int unsigned BLINK_FRAMES    = DEF_BLINK_FRAMES,
    parameter int unsigned BANNER_FRAMES   = DEF_BANNER_FRAMES,
    parameter int unsigned GAMEOVER_FRAMES = DEF_GAMEOVER_FRAMES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic [1:0] gameState,
    input  logic       levelUp,
    output logic       titleVisible,
    output logic       pressSpaceVisible,
    output logic       lifeVisible,
    output logic       levelVisible,
    output logic       levelBannerVisible,
    output logic       pauseVisible,
    output logic       gameOverVisible,
    output logic       gameOverDone
);

    localparam int unsigned MAX_FRAMES = max_u(BANNER_FRAMES, GAMEOVER_FRAMES);
    localparam int unsigned CNT_W      = $clog2(MAX_FRAMES) + 1;

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    game_state_e      gs;
    logic             banner_restart, entry, blink_restart, blink_next, blink_phase;
    logic             banner_expire, over_expire;
    logic title_q, press_q, life_q, level_q, banner_q, pause_q, over_q, done_q;
    logic title_d, press_d, life_d, level_d, banner_d, pause_d, over_d, done_d;

    overlay_blink_gen #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink (
        .clk          (clk),
        .reset        (reset),
        .restart      (blink_restart),
        .startOfFrame (startOfFrame),
        .phase        (blink_phase),
        .phase_next_c (blink_next)
    );

    // Next state, frame counter and output decode from the next state.
    always_comb begin
        state_d        = state_q;
        banner_restart = 1'b0;
        done_d         = 1'b0;
        gs             = game_state_e'(gameState);
        banner_expire  = startOfFrame && (cnt_q == CNT_W'(BANNER_FRAMES - 1));
        over_expire    = startOfFrame && (cnt_q == CNT_W'(GAMEOVER_FRAMES - 1));

        case (gs)
            GS_TITLE: state_d = S_TITLE;
            GS_GAMEOVER: begin
                if (state_q == S_OVER) begin
                    if (over_expire) begin
                        state_d = S_OVER_DONE;
                        done_d  = 1'b1;
                    end
                end else if (state_q != S_OVER_DONE) begin
                    state_d = S_OVER;
                end
            end
            GS_PAUSE: state_d = S_PAUSE;
            GS_PLAY: begin
                case (state_q)
                    S_TITLE, S_OVER, S_OVER_DONE: state_d = S_BANNER;
                    S_PAUSE: state_d = S_PLAY;
                    S_PLAY:  if (levelUp) state_d = S_BANNER;
                    S_BANNER: begin
                        // A level-up while the banner is showing restarts its timer.
                        if (levelUp)            banner_restart = 1'b1;
                        else if (banner_expire) state_d = S_PLAY;
                    end
                    default: state_d = S_TITLE;
                endcase
            end
        endcase

        entry         = (state_d != state_q) || banner_restart;
        blink_restart = (state_d != state_q) &&
                        ((state_d == S_TITLE) || (state_d == S_PAUSE) || (state_d == S_OVER_DONE));

        // Frame pulses coincident with an entry are not counted.
        cnt_d = cnt_q;
        if (entry) begin
            cnt_d = '0;
        end else if (startOfFrame && (cnt_q != CNT_W'(MAX_FRAMES))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        title_d  = (state_d == S_TITLE);
        press_d  = ((state_d == S_TITLE) || (state_d == S_OVER_DONE)) && blink_next;
        life_d   = (state_d == S_BANNER) || (state_d == S_PLAY) || (state_d == S_PAUSE);
        level_d  = life_d;
        banner_d = (state_d == S_BANNER);
        pause_d  = (state_d == S_PAUSE) && blink_next;
        over_d   = (state_d == S_OVER) || (state_d == S_OVER_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_TITLE;
            cnt_q    <= '0;
            title_q  <= 1'b1;
            press_q  <= 1'b1;
            life_q   <= 1'b0;
            level_q  <= 1'b0;
            banner_q <= 1'b0;
            pause_q  <= 1'b0;
            over_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            title_q  <= title_d;
            press_q  <= press_d;
            life_q   <= life_d;
            level_q  <= level_d;
            banner_q <= banner_d;
            pause_q  <= pause_d;
            over_q   <= over_d;
            done_q   <= done_d;
        end
    end

    assign titleVisible       = title_q;
    assign pressSpaceVisible  = press_q;
    assign lifeVisible        = life_q;
    assign levelVisible       = level_q;
    assign levelBannerVisible = banner_q;
    assign pauseVisible       = pause_q;
    assign gameOverVisible    = over_q;
    assign gameOverDone       = done_q;

    // The registered phase itself is only observed through blink_next.
    logic unused_ok;
    assign unused_ok = blink_phase;

endmodule

// File: tb/tb_overlay_sequencer.sv
// Self-checking bench for overlay_sequencer: directed scenarios followed by
// randomized traffic, every cycle compared against a behavioural model.
module tb_overlay_sequencer;

    localparam int BLINK  = 30;
    localparam int BANNER = 120;
    localparam int GO     = 180;

    localparam int M_TITLE = 0, M_BANNER = 1, M_PLAY = 2, M_PAUSE = 3, M_OVER = 4, M_OVER_DONE = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       startOfFrame = 1'b0;
    logic [1:0] gameState = 2'd0;
    logic       levelUp = 1'b0;
    logic titleVisible, pressSpaceVisible, lifeVisible, levelVisible;
    logic levelBannerVisible, pauseVisible, gameOverVisible, gameOverDone;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    // Model: current mode, frame pulses seen since entering it, done pulse.
    int m_mode   = M_TITLE;
    int m_frames = 0;
    bit m_done   = 1'b0;

    overlay_sequencer #(
        .BLINK_FRAMES    (BLINK),
        .BANNER_FRAMES   (BANNER),
        .GAMEOVER_FRAMES (GO)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .startOfFrame       (startOfFrame),
        .gameState          (gameState),
        .levelUp            (levelUp),
        .titleVisible       (titleVisible),
        .pressSpaceVisible  (pressSpaceVisible),
        .lifeVisible        (lifeVisible),
        .levelVisible       (levelVisible),
        .levelBannerVisible (levelBannerVisible),
        .pauseVisible       (pauseVisible),
        .gameOverVisible    (gameOverVisible),
        .gameOverDone       (gameOverDone)
    );

    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input int g, input bit l, input bit s);
        int  nm;
        bit  restart;
        if (r) begin
            m_mode = M_TITLE; m_frames = 0; m_done = 1'b0;
            return;
        end
        nm = m_mode; restart = 1'b0; m_done = 1'b0;
        if (g == 0) nm = M_TITLE;
        else if (g == 2) begin
            if (m_mode == M_OVER) begin
                if (s && (m_frames + 1 == GO)) begin nm = M_OVER_DONE; m_done = 1'b1; end
            end else if (m_mode != M_OVER_DONE) nm = M_OVER;
        end else if (g == 3) nm = M_PAUSE;
        else begin
            if (m_mode == M_TITLE || m_mode == M_OVER || m_mode == M_OVER_DONE) nm = M_BANNER;
            else if (m_mode == M_PAUSE) nm = M_PLAY;
            else if (m_mode == M_PLAY && l) nm = M_BANNER;
            else if (m_mode == M_BANNER) begin
                if (l) restart = 1'b1;
                else if (s && (m_frames + 1 == BANNER)) nm = M_PLAY;
            end
        end
        if (nm != m_mode || restart) m_frames = 0;
        else if (s) m_frames++;
        m_mode = nm;
    endtask

    task automatic check_outputs();
        bit blink;
        blink = ((m_frames / BLINK) % 2) == 0;
        check_bit("title",  titleVisible,       m_mode == M_TITLE);
        check_bit("press",  pressSpaceVisible,  (m_mode == M_TITLE || m_mode == M_OVER_DONE) && blink);
        check_bit("life",   lifeVisible,        m_mode == M_BANNER || m_mode == M_PLAY || m_mode == M_PAUSE);
        check_bit("level",  levelVisible,       m_mode == M_BANNER || m_mode == M_PLAY || m_mode == M_PAUSE);
        check_bit("banner", levelBannerVisible, m_mode == M_BANNER);
        check_bit("pause",  pauseVisible,       m_mode == M_PAUSE && blink);
        check_bit("over",   gameOverVisible,    m_mode == M_OVER || m_mode == M_OVER_DONE);
        check_bit("done",   gameOverDone,       m_done);
    endtask

    // One clock: drive inputs, let the edge happen, update model, sample at negedge.
    task automatic cycle(input bit r, input logic [1:0] g, input bit l, input bit s);
        reset = r; gameState = g; levelUp = l; startOfFrame = s;
        @(posedge clk);
        model_step(r, int'(g), l, s);
        @(negedge clk);
        if (gameOverDone === 1'b1) done_seen++;
        check_outputs();
    endtask

    task automatic frames(input int n, input logic [1:0] g);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, g, 1'b0, 1'b1);
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) cycle(1'b0, g, 1'b0, 1'b0);
        end
    endtask

    initial begin
        int n;
        int d0;
        logic [1:0] gs_r;

        // Reset and title blinking
        cycle(1'b1, 2'd0, 1'b0, 1'b0);
        cycle(1'b1, 2'd0, 1'b0, 1'b0);
        check_bit("rst_title", titleVisible, 1'b1);
        check_bit("rst_press", pressSpaceVisible, 1'b1);
        check_bit("rst_done",  gameOverDone, 1'b0);
        frames(65, 2'd0);

        // Play entry: banner on the next edge, drops on the 120th frame
        cycle(1'b0, 2'd1, 1'b0, 1'b0);
        check_bit("entry_banner", levelBannerVisible, 1'b1);
        frames(125, 2'd1);
        check_bit("banner_gone", levelBannerVisible, 1'b0);

        // Level-up banner restarted at frame 50 by a coincident level-up
        cycle(1'b0, 2'd1, 1'b1, 1'b0);
        n = 0;
        while (n < 400) begin
            n++;
            cycle(1'b0, 2'd1, (n == 50), 1'b1);
            if (levelBannerVisible !== 1'b1) break;
            cycle(1'b0, 2'd1, 1'b0, 1'b0);
        end
        check_int("banner_len", n, 170);

        // Pause in the middle of a banner, then resume without banner
        cycle(1'b0, 2'd1, 1'b1, 1'b0);
        frames(40, 2'd1);
        cycle(1'b0, 2'd3, 1'b0, 1'b0);
        frames(70, 2'd3);
        cycle(1'b0, 2'd1, 1'b0, 1'b0);
        check_bit("resume_banner", levelBannerVisible, 1'b0);
        check_bit("resume_life",   lifeVisible, 1'b1);

        // Game-over hold expires once, then blinking prompt
        d0 = done_seen;
        cycle(1'b0, 2'd2, 1'b0, 1'b0);
        frames(250, 2'd2);
        check_int("done_once", done_seen - d0, 1);

        // Leaving game-over before expiry never pulses
        cycle(1'b0, 2'd0, 1'b0, 1'b0);
        cycle(1'b0, 2'd1, 1'b0, 1'b0);
        d0 = done_seen;
        cycle(1'b0, 2'd2, 1'b0, 1'b0);
        frames(100, 2'd2);
        cycle(1'b0, 2'd0, 1'b0, 1'b0);
        frames(100, 2'd0);
        check_int("no_done", done_seen - d0, 0);

        // Reset mid-banner returns to title; the next banner runs its full length
        cycle(1'b0, 2'd1, 1'b0, 1'b0);
        frames(60, 2'd1);
        cycle(1'b1, 2'd1, 1'b0, 1'b1);
        check_bit("rst_mid_title",  titleVisible, 1'b1);
        check_bit("rst_mid_banner", levelBannerVisible, 1'b0);
        cycle(1'b0, 2'd1, 1'b0, 1'b0);
        frames(119, 2'd1);
        check_bit("banner_119", levelBannerVisible, 1'b1);
        frames(1, 2'd1);
        check_bit("banner_120", levelBannerVisible, 1'b0);

        // Randomized traffic against the model
        gs_r = 2'd0;
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 249) == 0) gs_r = 2'($urandom_range(0, 3));
            cycle(($urandom_range(0, 4999) == 0), gs_r,
                  ($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/overlay_sequencer.md
# overlay_sequencer

- Drives the visibility enables for every screen overlay: title, press-space prompt, life bar, level number, level banner, pause text, game-over text.
- Sits between the game-state FSM and the drawing/priority mux.
- Replaces the purely combinational state decode with a frame-timed sequencer that adds:
  - blinking prompts,
  - a timed level banner on play entry and on each level-up,
  - a pause state,
  - a timed game-over hold with a done pulse.

## Interface

Parameters:
- BLINK_FRAMES, default 30: frames per blink half-period (≥1).
- BANNER_FRAMES, default 120: frames the level banner stays up (≥1).
- GAMEOVER_FRAMES, default 180: frames before game-over hold completes (≥1).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; all state and counters cleared on the edge it is sampled high.
- startOfFrame  in  1  one-cycle pulse per video frame.
- gameState  in  2  0=TITLE, 1=PLAY, 2=GAMEOVER, 3=PAUSE.
- levelUp  in  1  one-cycle pulse on level advance.
- titleVisible  out  1
- pressSpaceVisible  out  1
- lifeVisible  out  1
- levelVisible  out  1
- levelBannerVisible  out  1
- pauseVisible  out  1
- gameOverVisible  out  1
- gameOverDone  out  1  one-cycle pulse when the game-over hold expires.

## Operation

Internal states:
- S_TITLE (reset state)
- S_BANNER
- S_PLAY
- S_PAUSE
- S_OVER
- S_OVER_DONE

Transitions are evaluated every cycle. Priority is top to bottom:
- gameState=0 → S_TITLE, from any state.
- gameState=2 → S_OVER, from any state except S_OVER and S_OVER_DONE.
- gameState=3 → S_PAUSE, from any state. An active banner is abandoned.
- gameState=1 handling:
  - from S_TITLE, S_OVER or S_OVER_DONE → S_BANNER;
  - from S_PAUSE → S_PLAY (banner not resumed);
  - in S_PLAY, levelUp → S_BANNER;
  - in S_BANNER, levelUp restarts the banner count at 0.
- S_BANNER → S_PLAY on the startOfFrame that brings frameCnt to BANNER_FRAMES.
- S_OVER → S_OVER_DONE on the startOfFrame that brings frameCnt to GAMEOVER_FRAMES. gameOverDone is high for exactly that one cycle.

frameCnt:
- Cleared on every state entry.
- Increments on startOfFrame.
- Saturates at max(BANNER_FRAMES, GAMEOVER_FRAMES).
- Width is $clog2 of that value plus 1.

Blink phase:
- Set to 1 (visible) on entry to S_TITLE, S_PAUSE and S_OVER_DONE.
- Toggles on every BLINK_FRAMES-th startOfFrame since entry.

Output decode (all 0 unless listed):
- S_TITLE: titleVisible=1, pressSpaceVisible=blink.
- S_BANNER: lifeVisible, levelVisible and levelBannerVisible = 1.
- S_PLAY: lifeVisible=1, levelVisible=1.
- S_PAUSE: lifeVisible=1, levelVisible=1, pauseVisible=blink.
- S_OVER: gameOverVisible=1.
- S_OVER_DONE: gameOverVisible=1, pressSpaceVisible=blink.

## Timing

- After reset, every output is 0 except:
  - titleVisible=1,
  - pressSpaceVisible=1.
- gameOverDone resets to 0.
- Latency from a gameState change to the new output pattern is 1 cycle (next rising edge). Outputs are registered and glitch-free.
- levelUp and startOfFrame in the same cycle in S_BANNER: the restart wins and frameCnt becomes 0.
- levelUp outside S_PLAY or S_BANNER is ignored.
- gameState and levelUp in the same cycle: the gameState transition wins.
- startOfFrame in the same cycle as a state entry is not counted.
- gameOverDone never asserts if gameState leaves 2 before expiry.
- Reset asserted mid-banner or mid-hold: returns to S_TITLE next edge; no pulse is emitted.

## Structure

- overlay_pkg holds:
  - the gameState encoding typedef: GS_TITLE, GS_PLAY, GS_GAMEOVER, GS_PAUSE;
  - the sequencer state enum;
  - the default frame constants.
- Sub-module overlay_blink_gen:
  - inputs: clk, reset, restart, startOfFrame;
  - parameter: BLINK_FRAMES;
  - output: phase.
  - Instantiated once and shared, since only one blinking state is active at a time.

## Test plan

- Reset, then 65 frames in TITLE (BLINK_FRAMES=30) → pressSpaceVisible is 1 for frames 0–29, 0 for 30–59, 1 from frame 60; titleVisible stays 1.
- gameState 0→1 → one cycle later levelBannerVisible, lifeVisible and levelVisible are 1. On the 120th startOfFrame the banner drops to 0.
- In PLAY, levelUp → banner for 120 frames. A second levelUp at frame 50, coincident with startOfFrame, → banner lasts until frame 170 measured from the first levelUp.
- PLAY→PAUSE at banner frame 40, then back to PLAY → pauseVisible blinks; on return levelBannerVisible=0 and lifeVisible=1.
- gameState=2 → gameOverVisible=1; gameOverDone pulses exactly once at frame 180, then pressSpaceVisible blinks. A repeat run leaving to TITLE at frame 100 → no pulse.
- Reset asserted at banner frame 60 → next edge shows the title pattern and frameCnt=0.
